// File: rtl/bp_me_axi_arb_pkg.sv
// bp_me_axi_arb_pkg: FSM state enums, AXI address-header struct and fixed AXI attribute constants
package bp_me_axi_arb_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ax_hdr_s;

    localparam logic [3:0] AXI_CACHE = 4'b0011;
    localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/bp_me_axi_rr_grant.sv
// bp_me_axi_rr_grant: two-way round-robin grant, captured on request and held until advanced
module bp_me_axi_rr_grant (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       capture_i,
    input  logic       advance_i,
    output logic       gnt_o
);

    logic ptr_q, ptr_d, gnt_q, gnt_d;

    // Pointer holder wins a tie; on completion the pointer moves away from the finished grant
    always_comb begin
        gnt_d = capture_i ? (req_i[ptr_q] ? ptr_q : ~ptr_q) : gnt_q;
        ptr_d = advance_i ? ~gnt_q : ptr_q;
    end

    // Grant and pointer registers, pointer starts at requester 0
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
            gnt_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: rtl/bp_me_axi_mem_arbiter.sv
// bp_me_axi_mem_arbiter: shares one AXI4 memory port between two managers (BP_MEM_ARB_PERF_EN adds perf counters)
module bp_me_axi_mem_arbiter
    import bp_me_axi_arb_pkg::*;
#(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 128,
    parameter int id_width_p = 4,
    parameter logic [addr_width_p-1:0] dram_base_addr_p = '0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic [addr_width_p-1:0] r0_araddr_i, r1_araddr_i,
    input  logic [id_width_p-1:0] r0_arid_i, r1_arid_i,
    input  logic [7:0] r0_arlen_i, r1_arlen_i,
    input  logic [2:0] r0_arsize_i, r1_arsize_i,
    input  logic [1:0] r0_arburst_i, r1_arburst_i,
    input  logic r0_arvalid_i, r1_arvalid_i,
    output logic r0_arready_o, r1_arready_o,
    output logic [data_width_p-1:0] r0_rdata_o, r1_rdata_o,
    output logic [id_width_p-1:0] r0_rid_o, r1_rid_o,
    output logic [1:0] r0_rresp_o, r1_rresp_o,
    output logic r0_rlast_o, r1_rlast_o, r0_rvalid_o, r1_rvalid_o,
    input  logic r0_rready_i, r1_rready_i,
    input  logic [addr_width_p-1:0] r0_awaddr_i, r1_awaddr_i,
    input  logic [id_width_p-1:0] r0_awid_i, r1_awid_i,
    input  logic [7:0] r0_awlen_i, r1_awlen_i,
    input  logic [2:0] r0_awsize_i, r1_awsize_i,
    input  logic [1:0] r0_awburst_i, r1_awburst_i,
    input  logic r0_awvalid_i, r1_awvalid_i,
    output logic r0_awready_o, r1_awready_o,
    input  logic [data_width_p-1:0] r0_wdata_i, r1_wdata_i,
    input  logic [data_width_p/8-1:0] r0_wstrb_i, r1_wstrb_i,
    input  logic r0_wlast_i, r1_wlast_i, r0_wvalid_i, r1_wvalid_i,
    output logic r0_wready_o, r1_wready_o,
    output logic [id_width_p-1:0] r0_bid_o, r1_bid_o,
    output logic [1:0] r0_bresp_o, r1_bresp_o,
    output logic r0_bvalid_o, r1_bvalid_o,
    input  logic r0_bready_i, r1_bready_i,
    output logic [addr_width_p-1:0] m_araddr_o,
    output logic [id_width_p-1:0] m_arid_o,
    output logic [7:0] m_arlen_o,
    output logic [2:0] m_arsize_o,
    output logic [1:0] m_arburst_o,
    output logic m_arvalid_o, m_arlock_o,
    output logic [3:0] m_arcache_o, m_arqos_o, m_arregion_o,
    output logic [2:0] m_arprot_o,
    input  logic m_arready_i,
    input  logic [data_width_p-1:0] m_rdata_i,
    input  logic [id_width_p-1:0] m_rid_i,
    input  logic [1:0] m_rresp_i,
    input  logic m_rlast_i, m_rvalid_i,
    output logic m_rready_o,
    output logic [addr_width_p-1:0] m_awaddr_o,
    output logic [id_width_p-1:0] m_awid_o,
    output logic [7:0] m_awlen_o,
    output logic [2:0] m_awsize_o,
    output logic [1:0] m_awburst_o,
    output logic m_awvalid_o, m_awlock_o,
    output logic [3:0] m_awcache_o, m_awqos_o, m_awregion_o,
    output logic [2:0] m_awprot_o,
    input  logic m_awready_i,
    output logic [data_width_p-1:0] m_wdata_o,
    output logic [data_width_p/8-1:0] m_wstrb_o,
    output logic m_wlast_o, m_wvalid_o,
    input  logic m_wready_i,
    input  logic [id_width_p-1:0] m_bid_i,
    input  logic [1:0] m_bresp_i,
    input  logic m_bvalid_i,
    output logic m_bready_o
`ifdef BP_MEM_ARB_PERF_EN
    ,output logic [31:0] perf_rd_cnt_o [2]
    ,output logic [31:0] perf_wr_cnt_o [2]
    ,output logic [31:0] perf_rd_wait_o [2]
`endif
);

    rd_state_e rd_st_q, rd_st_d;
    wr_state_e wr_st_q, wr_st_d;
    logic rd_gnt, wr_gnt, rd_cap, rd_adv, wr_cap, wr_adv;
    ax_hdr_s ar_hdr, aw_hdr;

    bp_me_axi_rr_grant rd_rr (
        .clk_i, .reset_i, .req_i({r1_arvalid_i, r0_arvalid_i}),
        .capture_i(rd_cap), .advance_i(rd_adv), .gnt_o(rd_gnt)
    );

    bp_me_axi_rr_grant wr_rr (
        .clk_i, .reset_i, .req_i({r1_awvalid_i, r0_awvalid_i}),
        .capture_i(wr_cap), .advance_i(wr_adv), .gnt_o(wr_gnt)
    );

    assign ar_hdr = rd_gnt ? {r1_arlen_i, r1_arsize_i, r1_arburst_i} : {r0_arlen_i, r0_arsize_i, r0_arburst_i};
    assign aw_hdr = wr_gnt ? {r1_awlen_i, r1_awsize_i, r1_awburst_i} : {r0_awlen_i, r0_awsize_i, r0_awburst_i};
    assign m_araddr_o = (rd_gnt ? r1_araddr_i : r0_araddr_i) - dram_base_addr_p;
    assign m_awaddr_o = (wr_gnt ? r1_awaddr_i : r0_awaddr_i) - dram_base_addr_p;
    assign m_arid_o = rd_gnt ? r1_arid_i : r0_arid_i;
    assign m_awid_o = wr_gnt ? r1_awid_i : r0_awid_i;
    assign {m_arlen_o, m_arsize_o, m_arburst_o} = {ar_hdr.len, ar_hdr.size, ar_hdr.burst};
    assign {m_awlen_o, m_awsize_o, m_awburst_o} = {aw_hdr.len, aw_hdr.size, aw_hdr.burst};
    assign {m_arlock_o, m_arcache_o, m_arprot_o, m_arqos_o, m_arregion_o} = {1'b0, AXI_CACHE, AXI_PROT, 4'd0, 4'd0};
    assign {m_awlock_o, m_awcache_o, m_awprot_o, m_awqos_o, m_awregion_o} = {1'b0, AXI_CACHE, AXI_PROT, 4'd0, 4'd0};
    assign m_wdata_o = wr_gnt ? r1_wdata_i : r0_wdata_i;
    assign m_wstrb_o = wr_gnt ? r1_wstrb_i : r0_wstrb_i;
    assign m_wlast_o = wr_gnt ? r1_wlast_i : r0_wlast_i;
    assign {r0_rdata_o, r0_rid_o, r0_rresp_o, r0_rlast_o} = {m_rdata_i, m_rid_i, m_rresp_i, m_rlast_i};
    assign {r1_rdata_o, r1_rid_o, r1_rresp_o, r1_rlast_o} = {m_rdata_i, m_rid_i, m_rresp_i, m_rlast_i};
    assign {r0_bid_o, r0_bresp_o} = {m_bid_i, m_bresp_i};
    assign {r1_bid_o, r1_bresp_o} = {m_bid_i, m_bresp_i};

    // Read path: arbitrate, issue AR, route R beats to the granted requester until rlast
    always_comb begin
        rd_st_d = rd_st_q;
        {rd_cap, rd_adv, m_arvalid_o, m_rready_o} = '0;
        {r0_arready_o, r1_arready_o, r0_rvalid_o, r1_rvalid_o} = '0;
        case (rd_st_q)
            R_IDLE: if (r0_arvalid_i | r1_arvalid_i) begin
                rd_cap = 1'b1;
                rd_st_d = R_ADDR;
            end
            R_ADDR: begin
                m_arvalid_o = 1'b1;
                r0_arready_o = m_arready_i & ~rd_gnt;
                r1_arready_o = m_arready_i & rd_gnt;
                if (m_arready_i) rd_st_d = R_DATA;
            end
            R_DATA: begin
                m_rready_o = rd_gnt ? r1_rready_i : r0_rready_i;
                r0_rvalid_o = m_rvalid_i & ~rd_gnt;
                r1_rvalid_o = m_rvalid_i & rd_gnt;
                if (m_rvalid_i & m_rready_o & m_rlast_i) begin
                    rd_adv = 1'b1;
                    rd_st_d = R_IDLE;
                end
            end
            default: rd_st_d = R_IDLE;
        endcase
    end

    // Write path: arbitrate, issue AW, then W, then B, all held on one grant
    always_comb begin
        wr_st_d = wr_st_q;
        {wr_cap, wr_adv, m_awvalid_o, m_wvalid_o, m_bready_o} = '0;
        {r0_awready_o, r1_awready_o, r0_wready_o, r1_wready_o, r0_bvalid_o, r1_bvalid_o} = '0;
        case (wr_st_q)
            W_IDLE: if (r0_awvalid_i | r1_awvalid_i) begin
                wr_cap = 1'b1;
                wr_st_d = W_ADDR;
            end
            W_ADDR: begin
                m_awvalid_o = 1'b1;
                r0_awready_o = m_awready_i & ~wr_gnt;
                r1_awready_o = m_awready_i & wr_gnt;
                if (m_awready_i) wr_st_d = W_DATA;
            end
            W_DATA: begin
                m_wvalid_o = wr_gnt ? r1_wvalid_i : r0_wvalid_i;
                r0_wready_o = m_wready_i & ~wr_gnt;
                r1_wready_o = m_wready_i & wr_gnt;
                if (m_wvalid_o & m_wready_i & m_wlast_o) wr_st_d = W_RESP;
            end
            W_RESP: begin
                m_bready_o = wr_gnt ? r1_bready_i : r0_bready_i;
                r0_bvalid_o = m_bvalid_i & ~wr_gnt;
                r1_bvalid_o = m_bvalid_i & wr_gnt;
                if (m_bvalid_i & m_bready_o) begin
                    wr_adv = 1'b1;
                    wr_st_d = W_IDLE;
                end
            end
            default: wr_st_d = W_IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight transaction
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_st_q <= R_IDLE;
            wr_st_q <= W_IDLE;
        end else begin
            rd_st_q <= rd_st_d;
            wr_st_q <= wr_st_d;
        end
    end

`ifdef BP_MEM_ARB_PERF_EN
    logic [31:0] perf_rd_cnt_q [2], perf_rd_cnt_d [2];
    logic [31:0] perf_wr_cnt_q [2], perf_wr_cnt_d [2];
    logic [31:0] perf_rd_wait_q [2], perf_rd_wait_d [2];

    // Completed transactions per requester and cycles a read request sat without the grant
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            perf_rd_cnt_d[i] = perf_rd_cnt_q[i] + 32'(rd_adv & (rd_gnt == 1'(i)));
            perf_wr_cnt_d[i] = perf_wr_cnt_q[i] + 32'(wr_adv & (wr_gnt == 1'(i)));
            perf_rd_wait_d[i] = perf_rd_wait_q[i] + 32'((i == 0 ? r0_arvalid_i : r1_arvalid_i)
                                & ~((rd_st_q != R_IDLE) & (rd_gnt == 1'(i))));
        end
    end

    // Perf counter registers, cleared by reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            perf_rd_cnt_q[i] <= reset_i ? '0 : perf_rd_cnt_d[i];
            perf_wr_cnt_q[i] <= reset_i ? '0 : perf_wr_cnt_d[i];
            perf_rd_wait_q[i] <= reset_i ? '0 : perf_rd_wait_d[i];
        end
    end

    assign perf_rd_cnt_o = perf_rd_cnt_q;
    assign perf_wr_cnt_o = perf_wr_cnt_q;
    assign perf_rd_wait_o = perf_rd_wait_q;
`endif

endmodule

// File: tb/tb_bp_me_axi_mem_arbiter.sv
// tb_bp_me_axi_mem_arbiter: directed self-checking bench for the two-manager AXI memory arbiter
module tb_bp_me_axi_mem_arbiter;

    localparam int AW = 64, DW = 128, IW = 4;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0, reset_i;
    logic [AW-1:0] r0_araddr_i, r1_araddr_i, r0_awaddr_i, r1_awaddr_i, m_araddr_o, m_awaddr_o;
    logic [IW-1:0] r0_arid_i, r1_arid_i, r0_awid_i, r1_awid_i, r0_rid_o, r1_rid_o, r0_bid_o, r1_bid_o;
    logic [IW-1:0] m_arid_o, m_awid_o, m_rid_i, m_bid_i;
    logic [7:0] r0_arlen_i, r1_arlen_i, r0_awlen_i, r1_awlen_i, m_arlen_o, m_awlen_o;
    logic [2:0] r0_arsize_i, r1_arsize_i, r0_awsize_i, r1_awsize_i, m_arsize_o, m_awsize_o, m_arprot_o, m_awprot_o;
    logic [1:0] r0_arburst_i, r1_arburst_i, r0_awburst_i, r1_awburst_i, m_arburst_o, m_awburst_o;
    logic [1:0] r0_rresp_o, r1_rresp_o, r0_bresp_o, r1_bresp_o, m_rresp_i, m_bresp_i;
    logic [3:0] m_arcache_o, m_awcache_o, m_arqos_o, m_awqos_o, m_arregion_o, m_awregion_o;
    logic [DW-1:0] r0_rdata_o, r1_rdata_o, r0_wdata_i, r1_wdata_i, m_rdata_i, m_wdata_o;
    logic [DW/8-1:0] r0_wstrb_i, r1_wstrb_i, m_wstrb_o;
    logic r0_arvalid_i, r1_arvalid_i, r0_arready_o, r1_arready_o;
    logic r0_rlast_o, r1_rlast_o, r0_rvalid_o, r1_rvalid_o, r0_rready_i, r1_rready_i;
    logic r0_awvalid_i, r1_awvalid_i, r0_awready_o, r1_awready_o;
    logic r0_wlast_i, r1_wlast_i, r0_wvalid_i, r1_wvalid_i, r0_wready_o, r1_wready_o;
    logic r0_bvalid_o, r1_bvalid_o, r0_bready_i, r1_bready_i;
    logic m_arvalid_o, m_arlock_o, m_arready_i, m_rlast_i, m_rvalid_i, m_rready_o;
    logic m_awvalid_o, m_awlock_o, m_awready_i, m_wlast_o, m_wvalid_o, m_wready_i;
    logic m_bvalid_i, m_bready_o;
`ifdef BP_MEM_ARB_PERF_EN
    logic [31:0] perf_rd_cnt_o [2], perf_wr_cnt_o [2], perf_rd_wait_o [2];
`endif

    int checks = 0, failures = 0;

    bp_me_axi_mem_arbiter #(.dram_base_addr_p(BASE)) dut (
        .clk_i(clk), .reset_i,
        .r0_araddr_i, .r1_araddr_i, .r0_arid_i, .r1_arid_i, .r0_arlen_i, .r1_arlen_i,
        .r0_arsize_i, .r1_arsize_i, .r0_arburst_i, .r1_arburst_i, .r0_arvalid_i, .r1_arvalid_i,
        .r0_arready_o, .r1_arready_o, .r0_rdata_o, .r1_rdata_o, .r0_rid_o, .r1_rid_o,
        .r0_rresp_o, .r1_rresp_o, .r0_rlast_o, .r1_rlast_o, .r0_rvalid_o, .r1_rvalid_o,
        .r0_rready_i, .r1_rready_i,
        .r0_awaddr_i, .r1_awaddr_i, .r0_awid_i, .r1_awid_i, .r0_awlen_i, .r1_awlen_i,
        .r0_awsize_i, .r1_awsize_i, .r0_awburst_i, .r1_awburst_i, .r0_awvalid_i, .r1_awvalid_i,
        .r0_awready_o, .r1_awready_o, .r0_wdata_i, .r1_wdata_i, .r0_wstrb_i, .r1_wstrb_i,
        .r0_wlast_i, .r1_wlast_i, .r0_wvalid_i, .r1_wvalid_i, .r0_wready_o, .r1_wready_o,
        .r0_bid_o, .r1_bid_o, .r0_bresp_o, .r1_bresp_o, .r0_bvalid_o, .r1_bvalid_o,
        .r0_bready_i, .r1_bready_i,
        .m_araddr_o, .m_arid_o, .m_arlen_o, .m_arsize_o, .m_arburst_o, .m_arvalid_o, .m_arlock_o,
        .m_arcache_o, .m_arqos_o, .m_arregion_o, .m_arprot_o, .m_arready_i,
        .m_rdata_i, .m_rid_i, .m_rresp_i, .m_rlast_i, .m_rvalid_i, .m_rready_o,
        .m_awaddr_o, .m_awid_o, .m_awlen_o, .m_awsize_o, .m_awburst_o, .m_awvalid_o, .m_awlock_o,
        .m_awcache_o, .m_awqos_o, .m_awregion_o, .m_awprot_o, .m_awready_i,
        .m_wdata_o, .m_wstrb_o, .m_wlast_o, .m_wvalid_o, .m_wready_i,
        .m_bid_i, .m_bresp_i, .m_bvalid_i, .m_bready_o
`ifdef BP_MEM_ARB_PERF_EN
        , .perf_rd_cnt_o, .perf_wr_cnt_o, .perf_rd_wait_o
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        {r0_arvalid_i, r1_arvalid_i, r0_awvalid_i, r1_awvalid_i, r0_wvalid_i, r1_wvalid_i} = '0;
        {m_arready_i, m_awready_i, m_rvalid_i, m_rlast_i, m_bvalid_i} = '0;
        step;
        step;
        reset_i = 1'b0;
    endtask

    task automatic set_ar(input bit req, input logic [63:0] addr, input logic [7:0] len);
        if (req) {r1_arvalid_i, r1_araddr_i, r1_arlen_i, r1_arid_i} = {1'b1, addr, len, 4'd3};
        else     {r0_arvalid_i, r0_araddr_i, r0_arlen_i, r0_arid_i} = {1'b1, addr, len, 4'd2};
    endtask

    task automatic set_aw(input bit req, input logic [63:0] addr, input logic [3:0] id);
        if (req) {r1_awvalid_i, r1_awaddr_i, r1_awid_i, r1_wvalid_i, r1_wlast_i, r1_wdata_i} = {1'b1, addr, id, 2'b11, addr, addr};
        else     {r0_awvalid_i, r0_awaddr_i, r0_awid_i, r0_wvalid_i, r0_wlast_i, r0_wdata_i} = {1'b1, addr, id, 2'b11, addr, addr};
    endtask

    task automatic rd_txn(input bit req, input logic [63:0] exp_addr, input int beats);
        step;
        check("ar_valid", m_arvalid_o, 1'b1);
        check("ar_addr", m_araddr_o, exp_addr);
        check("ar_len", m_arlen_o, 8'(beats - 1));
        check("ar_id", m_arid_o, req ? 4'd3 : 4'd2);
        m_arready_i = 1'b1;
        #1;
        check("ar_ready_gnt", req ? r1_arready_o : r0_arready_o, 1'b1);
        check("ar_ready_oth", req ? r0_arready_o : r1_arready_o, 1'b0);
        step;
        m_arready_i = 1'b0;
        if (req) r1_arvalid_i = 1'b0; else r0_arvalid_i = 1'b0;
        for (int b = 0; b < beats; b++) begin
            m_rvalid_i = 1'b1;
            m_rlast_i = (b == beats - 1);
            m_rdata_i = {64'(b), exp_addr};
            #1;
            check("r_valid_gnt", req ? r1_rvalid_o : r0_rvalid_o, 1'b1);
            check("r_valid_oth", req ? r0_rvalid_o : r1_rvalid_o, 1'b0);
            check("r_data", req ? r1_rdata_o : r0_rdata_o, {64'(b), exp_addr});
            step;
        end
        {m_rvalid_i, m_rlast_i} = '0;
        #1;
        check("r_done_rready", m_rready_o, 1'b0);
        check("r_done_arvalid", m_arvalid_o, 1'b0);
    endtask

    task automatic wr_txn(input bit req, input logic [63:0] exp_addr, input logic [3:0] exp_id);
        #1;
        check("w_pre_aw", req ? r1_wready_o : r0_wready_o, 1'b0);
        step;
        check("aw_valid", m_awvalid_o, 1'b1);
        check("aw_addr", m_awaddr_o, exp_addr);
        check("aw_id", m_awid_o, exp_id);
        check("w_in_aw", req ? r1_wready_o : r0_wready_o, 1'b0);
        m_awready_i = 1'b1;
        #1;
        check("aw_ready_gnt", req ? r1_awready_o : r0_awready_o, 1'b1);
        check("aw_ready_oth", req ? r0_awready_o : r1_awready_o, 1'b0);
        step;
        m_awready_i = 1'b0;
        if (req) r1_awvalid_i = 1'b0; else r0_awvalid_i = 1'b0;
        #1;
        check("w_valid", m_wvalid_o, 1'b1);
        check("w_ready_gnt", req ? r1_wready_o : r0_wready_o, 1'b1);
        check("w_ready_oth", req ? r0_wready_o : r1_wready_o, 1'b0);
        check("w_data", m_wdata_o, {2{exp_addr + BASE}});
        step;
        if (req) r1_wvalid_i = 1'b0; else r0_wvalid_i = 1'b0;
        m_bvalid_i = 1'b1;
        m_bid_i = exp_id;
        #1;
        check("b_valid_gnt", req ? r1_bvalid_o : r0_bvalid_o, 1'b1);
        check("b_valid_oth", req ? r0_bvalid_o : r1_bvalid_o, 1'b0);
        check("b_id", req ? r1_bid_o : r0_bid_o, exp_id);
        check("b_bready", m_bready_o, 1'b1);
        step;
        m_bvalid_i = 1'b0;
        #1;
        check("b_done", m_bready_o, 1'b0);
    endtask

    initial begin
        {r0_araddr_i, r1_araddr_i, r0_awaddr_i, r1_awaddr_i, r0_arid_i, r1_arid_i, r0_awid_i, r1_awid_i} = '0;
        {r0_arlen_i, r1_arlen_i, r0_awlen_i, r1_awlen_i, r0_arsize_i, r1_arsize_i, r0_awsize_i, r1_awsize_i} = '0;
        {r0_arburst_i, r1_arburst_i, r0_awburst_i, r1_awburst_i, m_rresp_i, m_bresp_i, m_rid_i, m_bid_i} = '0;
        {r0_wdata_i, r1_wdata_i, m_rdata_i, r0_wlast_i, r1_wlast_i} = '0;
        r0_wstrb_i = '1;
        r1_wstrb_i = '1;
        {r0_rready_i, r1_rready_i, r0_bready_i, r1_bready_i, m_wready_i} = '1;
        {r0_arvalid_i, r1_arvalid_i, r0_awvalid_i, r1_awvalid_i, r0_wvalid_i, r1_wvalid_i} = '0;
        {m_arready_i, m_awready_i, m_rvalid_i, m_rlast_i, m_bvalid_i} = '0;
        reset_i = 1'b1;
        step;
        {m_arready_i, m_rvalid_i, m_bvalid_i, r0_arvalid_i, r1_awvalid_i, r0_wvalid_i} = '1;
        step;
        check("rst_arvalid", m_arvalid_o, 1'b0);
        check("rst_awvalid", m_awvalid_o, 1'b0);
        check("rst_wvalid", m_wvalid_o, 1'b0);
        check("rst_rready", m_rready_o, 1'b0);
        check("rst_bready", m_bready_o, 1'b0);
        check("rst_arready", {r0_arready_o, r1_arready_o}, 2'b00);
        check("rst_rvalid", {r0_rvalid_o, r1_rvalid_o}, 2'b00);
        check("rst_wready_bvalid", {r0_wready_o, r1_wready_o, r0_bvalid_o, r1_bvalid_o}, 4'b0000);
        check("const_cache", {m_arcache_o, m_awcache_o}, 8'h33);
        check("const_prot_lock", {m_arprot_o, m_awprot_o, m_arlock_o, m_awlock_o}, 8'h00);
        do_reset;
        // r0 4-beat read with base subtraction, then back-to-back single requester read
        set_ar(0, 64'h8000_0040, 8'd3);
        rd_txn(0, 64'h40, 4);
        set_ar(0, 64'h8000_0080, 8'd1);
        rd_txn(0, 64'h80, 2);
        // simultaneous requests after reset: r0, then r1, then next tie to r0
        do_reset;
        set_ar(0, 64'h8000_0100, 8'd0);
        set_ar(1, 64'h8000_0200, 8'd0);
        rd_txn(0, 64'h100, 1);
        rd_txn(1, 64'h200, 1);
        set_ar(0, 64'h8000_0300, 8'd0);
        set_ar(1, 64'h8000_0400, 8'd0);
        rd_txn(0, 64'h300, 1);
        rd_txn(1, 64'h400, 1);
        // r1 presents W before AW
        do_reset;
        {r1_wvalid_i, r1_wlast_i, r1_wdata_i} = {2'b11, 64'h8000_1000, 64'h8000_1000};
        #1;
        check("w_early_ready", r1_wready_o, 1'b0);
        check("w_early_valid", m_wvalid_o, 1'b0);
        step;
        check("w_early_ready2", r1_wready_o, 1'b0);
        set_aw(1, 64'h8000_1000, 4'd5);
        wr_txn(1, 64'h1000, 4'd5);
        // concurrent r0 read and r1 write
        do_reset;
        set_ar(0, 64'h8000_0080, 8'd1);
        set_aw(1, 64'h8000_2000, 4'd3);
        step;
        check("cc_valids", {m_arvalid_o, m_awvalid_o}, 2'b11);
        check("cc_araddr", m_araddr_o, 64'h80);
        check("cc_awaddr", m_awaddr_o, 64'h2000);
        {m_arready_i, m_awready_i} = 2'b11;
        #1;
        check("cc_readies", {r0_arready_o, r1_arready_o, r0_awready_o, r1_awready_o}, 4'b1001);
        step;
        {m_arready_i, m_awready_i, r0_arvalid_i, r1_awvalid_i} = '0;
        {m_rvalid_i, m_rlast_i} = 2'b10;
        #1;
        check("cc_data1", {r0_rvalid_o, r1_rvalid_o, r0_wready_o, r1_wready_o, m_wvalid_o}, 5'b10011);
        step;
        r1_wvalid_i = 1'b0;
        {m_rlast_i, m_bvalid_i, m_bid_i} = {2'b11, 4'd3};
        #1;
        check("cc_data2", {r0_rvalid_o, r1_rvalid_o, r0_bvalid_o, r1_bvalid_o}, 4'b1001);
        check("cc_bid", r1_bid_o, 4'd3);
        step;
        {m_rvalid_i, m_rlast_i, m_bvalid_i} = '0;
        #1;
        check("cc_done", {m_rready_o, m_bready_o}, 2'b00);
        // reset during the second read beat aborts, then a fresh AR is served
        do_reset;
        set_ar(0, 64'h8000_0040, 8'd3);
        step;
        m_arready_i = 1'b1;
        step;
        {m_arready_i, r0_arvalid_i, m_rvalid_i} = 3'b001;
        step;
        reset_i = 1'b1;
        step;
        reset_i = 1'b0;
        #1;
        check("mid_rst_rvalid", r0_rvalid_o, 1'b0);
        check("mid_rst_idle", {m_rready_o, m_arvalid_o, m_awvalid_o}, 3'b000);
        m_rvalid_i = 1'b0;
        set_ar(1, 64'h8000_0500, 8'd1);
        rd_txn(1, 64'h500, 2);
`ifdef BP_MEM_ARB_PERF_EN
        do_reset;
        for (int k = 0; k < 3; k++) begin
            set_ar(0, 64'h8000_0600 + 64'(k * 16), 8'd0);
            rd_txn(0, 64'h600 + 64'(k * 16), 1);
        end
        for (int k = 0; k < 2; k++) begin
            set_aw(1, 64'h8000_3000, 4'd6);
            wr_txn(1, 64'h3000, 4'd6);
        end
        check("perf_rd0", perf_rd_cnt_o[0], 32'd3);
        check("perf_rd1", perf_rd_cnt_o[1], 32'd0);
        check("perf_wr0", perf_wr_cnt_o[0], 32'd0);
        check("perf_wr1", perf_wr_cnt_o[1], 32'd2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
